// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the bimodal branch predictor.
//   bp_state_t    : 2-bit saturating counter state, MSB is the prediction
//   BP_INIT_STATE : state every table entry takes on reset (weakly not-taken)
//   bp_next()     : saturating increment on taken, decrement on not-taken
// ---------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_t;

  localparam bp_state_t BP_INIT_STATE = WNT;

  // Saturating counter update. Written as an explicit case so the enum type
  // is preserved without arithmetic casts and the saturation ends are obvious.
  function automatic bp_state_t bp_next(bp_state_t s, logic taken);
    bp_state_t n;
    n = s;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = BP_INIT_STATE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side lookup, the memory-stage training inputs and the
// performance counters of the branch predictor.
//   pcF / predict_takenF          : fetch lookup and its same-cycle answer
//   branchM / pcM / takenM /
//   predict_resultM               : resolved branch information from M
//   branch_count / mispredict_count : event counters since reset
// master = pipeline side, slave = predictor side.
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
  parameter int CNT_WIDTH = 32
);

  logic [31:0]          pcF;
  logic                 predict_takenF;
  logic                 branchM;
  logic [31:0]          pcM;
  logic                 takenM;
  logic                 predict_resultM;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output pcF,
    output branchM,
    output pcM,
    output takenM,
    output predict_resultM,
    input  predict_takenF,
    input  branch_count,
    input  mispredict_count
  );

  modport slave (
    input  pcF,
    input  branchM,
    input  pcM,
    input  takenM,
    input  predict_resultM,
    output predict_takenF,
    output branch_count,
    output mispredict_count
  );

endinterface

// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Storage for the predictor: 2^INDEX_BITS flops of bp_state_t with one
// combinational read port and one training write port.
//   clk, rst  : clock, synchronous active-high reset (all entries -> WNT)
//   rdIdx     : lookup index from fetch
//   rdState   : state seen by fetch, write-first when rdIdx == wrIdx
//   wrEn      : a training event is present this cycle
//   wrIdx     : entry to train
//   wrTaken   : outcome to train with
// ---------------------------------------------------------------------------
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rdIdx,
  output bp_state_t             rdState,
  input  logic                  wrEn,
  input  logic [INDEX_BITS-1:0] wrIdx,
  input  logic                  wrTaken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  bp_state_t tableQ [ENTRIES];
  bp_state_t wrNext;

  // The post-update value of the trained entry is computed once and shared
  // between the register write and the fetch bypass, so both always agree.
  always_comb begin
    wrNext = bp_next(tableQ[wrIdx], wrTaken);
  end

  // Write-first read: a fetch that hits the entry being trained this cycle
  // already sees the trained value instead of the stale stored one.
  always_comb begin
    rdState = tableQ[rdIdx];
    if (wrEn && (wrIdx == rdIdx)) begin
      rdState = wrNext;
    end
  end

  // Reset discards all history and takes priority over a concurrent
  // training event; otherwise only the addressed entry changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tableQ[i] <= BP_INIT_STATE;
      end
    end else if (wrEn) begin
      tableQ[wrIdx] <= wrNext;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Bimodal branch predictor for the five-stage MIPS pipeline. Fetch gets a
// zero-latency taken/not-taken guess for pcF; resolved branches from M train
// a 2-bit saturating counter indexed by word-address bits of the PC. Two
// wrapping counters track resolved branches and mispredictions.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : branch_predictor_if.slave (lookup, training, counters)
// Parameters:
//   INDEX_BITS : log2 of table entries; index = pc[INDEX_BITS+1:2]
//   CNT_WIDTH  : width of the performance counters (must match bus)
// ---------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predictor_if.slave     bus
);

  logic [INDEX_BITS-1:0] idxF;
  logic [INDEX_BITS-1:0] idxM;
  bp_state_t             stateF;
  logic [CNT_WIDTH-1:0]  branchCount;
  logic [CNT_WIDTH-1:0]  mispredictCount;
  logic                  unusedPcBits;

  // Byte-offset bits and everything above the index are deliberately
  // ignored: PCs that differ only there alias onto the same entry.
  always_comb begin
    idxF = bus.pcF[INDEX_BITS+1:2];
    idxM = bus.pcM[INDEX_BITS+1:2];
  end

  assign unusedPcBits = ^{bus.pcF[31:INDEX_BITS+2], bus.pcF[1:0],
                          bus.pcM[31:INDEX_BITS+2], bus.pcM[1:0]};

  bp_table #(
    .INDEX_BITS (INDEX_BITS)
  ) uTable (
    .clk     (clk),
    .rst     (rst),
    .rdIdx   (idxF),
    .rdState (stateF),
    .wrEn    (bus.branchM),
    .wrIdx   (idxM),
    .wrTaken (bus.takenM)
  );

  // The prediction is simply the counter MSB (WT/ST predict taken).
  assign bus.predict_takenF = stateF[1];

  // Performance counters wrap freely; the M-stage result is only meaningful
  // when branchM qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      branchCount     <= '0;
      mispredictCount <= '0;
    end else if (bus.branchM) begin
      branchCount <= branchCount + CNT_WIDTH'(1);
      if (!bus.predict_resultM) begin
        mispredictCount <= mispredictCount + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.branch_count     = branchCount;
  assign bus.mispredict_count = mispredictCount;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor. Two instances share identical
// stimulus: one with default parameters and one with 4-bit counters so the
// counter wrap can be observed.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic clk;
  logic rst;

  int checkCount;
  int errorCount;

  branch_predictor_if #(.CNT_WIDTH(32)) busMain ();
  branch_predictor_if #(.CNT_WIDTH(4))  busSmall ();

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busMain)
  );

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(4)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busSmall)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through here so the tallies stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setFetch(input logic [31:0] pc);
    busMain.pcF  = pc;
    busSmall.pcF = pc;
    #1;
  endtask

  task automatic setM(input logic br, input logic [31:0] pc, input logic taken,
                      input logic result);
    busMain.branchM          = br;
    busMain.pcM              = pc;
    busMain.takenM           = taken;
    busMain.predict_resultM  = result;
    busSmall.branchM         = br;
    busSmall.pcM             = pc;
    busSmall.takenM          = taken;
    busSmall.predict_resultM = result;
  endtask

  // Present one M-stage cycle, then step past the edge and drop branchM so
  // later lookups see only stored state.
  task automatic applyStimulus(input logic br, input logic [31:0] pc,
                               input logic taken, input logic result);
    setM(br, pc, taken, result);
    @(posedge clk);
    #1;
    setM(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
  endtask

  int brVec  [15] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  int resVec [15] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    setM(1'b0, 32'h0, 1'b0, 1'b1);
    setFetch(32'h40);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    $display("[TB] reset state");
    checkOutput("resetPredict", {31'b0, busMain.predict_takenF}, 32'd0);
    checkOutput("resetBranchCnt", busMain.branch_count, 32'd0);
    checkOutput("resetMispCnt", busMain.mispredict_count, 32'd0);

    $display("[TB] saturation at 0x40");
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
    checkOutput("satWT", {31'b0, busMain.predict_takenF}, 32'd1);
    repeat (3) applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
    checkOutput("satST", {31'b0, busMain.predict_takenF}, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("satDownWT", {31'b0, busMain.predict_takenF}, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("satDownWNT", {31'b0, busMain.predict_takenF}, 32'd0);
    checkOutput("satBranchCnt", busMain.branch_count, 32'd6);

    $display("[TB] aliasing");
    setFetch(32'h0);
    checkOutput("aliasBefore", {31'b0, busMain.predict_takenF}, 32'd0);
    repeat (2) applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
    checkOutput("aliasHit", {31'b0, busMain.predict_takenF}, 32'd1);
    setFetch(32'h4);
    checkOutput("aliasNeighbour", {31'b0, busMain.predict_takenF}, 32'd0);
    setFetch(32'h40);
    checkOutput("idx16Untouched", {31'b0, busMain.predict_takenF}, 32'd0);

    $display("[TB] same-cycle bypass");
    setFetch(32'h80);
    checkOutput("bypassBefore", {31'b0, busMain.predict_takenF}, 32'd0);
    setM(1'b1, 32'h80, 1'b1, 1'b1);
    #1;
    checkOutput("bypassSameCycle", {31'b0, busMain.predict_takenF}, 32'd1);
    setM(1'b1, 32'h84, 1'b1, 1'b1);
    #1;
    checkOutput("bypassOtherIdx", {31'b0, busMain.predict_takenF}, 32'd0);
    setM(1'b1, 32'h80, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    setM(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("bypassStored", {31'b0, busMain.predict_takenF}, 32'd1);

    $display("[TB] performance counters");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(brVec[i][0], 32'h200 + 32'(i * 4), 1'b1, resVec[i][0]);
    end
    checkOutput("cnt10Branch", busMain.branch_count, 32'd10);
    checkOutput("cnt10Misp", busMain.mispredict_count, 32'd3);
    checkOutput("small10Branch", {28'b0, busSmall.branch_count}, 32'd10);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b1);
    end
    checkOutput("cnt17Branch", busMain.branch_count, 32'd17);
    checkOutput("small17Wrap", {28'b0, busSmall.branch_count}, 32'd1);
    checkOutput("small17Misp", {28'b0, busSmall.mispredict_count}, 32'd3);

    $display("[TB] reset mid-run");
    for (int e = 0; e < 3; e++) begin
      repeat (3) applyStimulus(1'b1, 32'h40 + 32'(e * 4), 1'b1, 1'b0);
    end
    setFetch(32'h44);
    checkOutput("trainedST", {31'b0, busMain.predict_takenF}, 32'd1);
    rst = 1'b1;
    setM(1'b1, 32'h48, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    setM(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    for (int e = 0; e < 3; e++) begin
      setFetch(32'h40 + 32'(e * 4));
      checkOutput($sformatf("rstPredict%0d", e),
                  {31'b0, busMain.predict_takenF}, 32'd0);
    end
    checkOutput("rstBranchCnt", busMain.branch_count, 32'd0);
    checkOutput("rstMispCnt", busMain.mispredict_count, 32'd0);
    checkOutput("rstSmallCnt", {28'b0, busSmall.branch_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor for the five-stage MIPS pipeline. It supplies the fetch stage with a taken/not-taken guess for the instruction at `pcF`, and it is trained one cycle after execute, when the branch outcome reaches M. The table holds 2-bit saturating counters indexed by word-address bits of the PC. The block also keeps branch and mispredict event counters for performance debug.

## Interface
Parameters:
- `INDEX_BITS`, default 6: table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- `CNT_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `pcF`  input  32  fetch-stage PC to predict for.
- `predict_takenF`  output  1  prediction for `pcF`; combinational from table state plus the same-cycle update bypass.
- `branchM`  input  1  a resolved conditional branch is in M this cycle; qualifies all other M inputs.
- `pcM`  input  32  PC of the branch in M.
- `takenM`  input  1  actual outcome of that branch (1 = taken).
- `predict_resultM`  input  1  1 = the prediction for that branch was correct.
- `branch_count`  output  CNT_WIDTH  number of resolved branches since reset.
- `mispredict_count`  output  CNT_WIDTH  number of mispredicted branches since reset.

## Operation
- Each table entry is a 2-bit state:
  - SNT = 00, WNT = 01, WT = 10, ST = 11.
  - Prediction = state[1].
- Lookup:
  - `idxF = pcF[INDEX_BITS+1:2]`.
  - `predict_takenF = next_or_current(idxF)[1]`.
- Update, applied when `branchM` = 1, with `idxM = pcM[INDEX_BITS+1:2]`:
  - If `takenM` = 1: the state increments, saturating at ST.
  - If `takenM` = 0: the state decrements, saturating at SNT.
  - No other entry changes.
- Bypass: when `branchM` = 1 and `idxM == idxF` in the same cycle, `predict_takenF` uses the post-update state, not the stored state (write-first behaviour).
- Aliasing: PCs that differ only above bit INDEX_BITS+1 share one entry. This is intended; no tags are kept.
- Counters:
  - `branch_count` increments by 1 on each cycle with `branchM` = 1.
  - `mispredict_count` increments by 1 on each cycle with `branchM` = 1 and `predict_resultM` = 0.
  - Both wrap modulo 2^CNT_WIDTH. They do not saturate.
- When `branchM` = 0, `pcM`, `takenM` and `predict_resultM` are don't-care and have no effect.

## Timing
- Reset (`rst` = 1 at an edge):
  - Every table entry becomes WNT (01).
  - Both counters become 0.
  - So after reset `predict_takenF` = 0 for every PC.
- While `rst` is asserted, updates are ignored; reset wins over a simultaneous `branchM`.
- Lookup latency is zero: `predict_takenF` is valid in the same cycle as `pcF`. There is no register on this path.
- Update latency is one edge: a training event in cycle N affects predictions from cycle N+1 onward, and in cycle N itself through the bypass.
- The stall and flush signals of the pipeline are not inputs to this block:
  - A stalled fetch re-reads the same `pcF`. The prediction may change if a training event hits the same index.
  - M is never stalled, so each branch is trained exactly once.
- Reset mid-operation discards all training history and zeroes the counters on that edge.
- Counter wrap: an increment from 2^CNT_WIDTH−1 gives 0 on the next edge.

## Structure
- Package `bp_pkg` holds:
  - enum `bp_state_t` (SNT/WNT/WT/ST);
  - constant `BP_INIT_STATE = WNT`;
  - function `bp_next(bp_state_t s, logic taken)` implementing the saturating update.
- Sub-module `bp_table` holds the storage:
  - flop array of 2^INDEX_BITS × `bp_state_t`;
  - synchronous reset to `BP_INIT_STATE`;
  - one combinational read port, one write port;
  - bypass mux inside.
- The top-level `branch_predictor` computes the indices, instantiates `bp_table`, and holds the two performance counters.

## Test plan
- Reset, then `pcF` = 0x0000_0040 → `predict_takenF` = 0. `branch_count` = `mispredict_count` = 0.
- Saturation up, with `branchM` = 1, `pcM` = 0x40, `takenM` = 1:
  - after one edge, `predict_takenF` for `pcF` = 0x40 reads 1 (WT);
  - after three more edges, the state stays ST;
  - one not-taken update then leaves the prediction at 1 (WT);
  - a second not-taken update gives 0.
- Aliasing and independence, with INDEX_BITS = 6:
  - train `pcM` = 0x100 taken twice → `pcF` = 0x000 predicts 1 (same index);
  - `pcF` = 0x004 still predicts 0.
- Bypass: in a single cycle apply `pcF` = `pcM` = 0x80, `branchM` = 1, `takenM` = 1 from WNT → `predict_takenF` = 1 in that same cycle.
- Counters, over 10 branch cycles with `predict_resultM` = 0 on 3 of them and 5 interleaved cycles with `branchM` = 0:
  - `branch_count` = 10, `mispredict_count` = 3;
  - with CNT_WIDTH = 4, 17 branches → `branch_count` = 1.
- Reset mid-run: train several entries to ST, then assert `rst` for one cycle together with `branchM` = 1 → all predictions return 0 and both counters read 0.
